// File: rtl/axis_trig_pkt_pkg.sv
// Shared definitions for the trigger packetizer: FSM state encoding.
package axis_trig_pkt_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ARMED = 3'd2;
  localparam logic [STATE_W-1:0] ST_POST  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = ST_IDLE,
    StPre   = ST_PRE,
    StArmed = ST_ARMED,
    StPost  = ST_POST,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/axis_trig_edge.sv
// Registered rising-edge detector; rise is high in the first cycle a level goes high.
module axis_trig_edge (
  input  logic aclk,
  input  logic aresetn,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Previous-cycle copy of the level.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/axis_trigger_packetizer.sv
// Circular-capture packetizer: passes a stream through with a guaranteed pre-trigger history,
// then a fixed post-trigger beat count ending in tlast. Optional macro AXIS_TRIG_TIMESTAMP_EN
// adds a free-running cycle counter latched alongside trigger_pos (output trig_timestamp).
module axis_trigger_packetizer
  import axis_trig_pkt_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 32,
  parameter int unsigned FRAME_WIDTH      = 16,
  parameter string       NON_BLOCKING     = "FALSE"
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_pre,
  input  logic [CNTR_WIDTH-1:0]       cfg_post,
  input  logic                        cfg_continuous,
  input  logic                        arm,
  input  logic                        trigger,
  output logic [CNTR_WIDTH-1:0]       trigger_pos,
  output logic [FRAME_WIDTH-1:0]      frame_cnt,
  output logic [STATE_W-1:0]          state_o,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
`ifdef AXIS_TRIG_TIMESTAMP_EN
  ,
  output logic [CNTR_WIDTH-1:0]       trig_timestamp
`endif
);

  localparam bit NonBlk = (NON_BLOCKING == "TRUE");

  state_e                 state_q, state_d;
  logic [CNTR_WIDTH-1:0]  pos_q, pos_d;
  logic [CNTR_WIDTH-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNTR_WIDTH-1:0]  post_cnt_q, post_cnt_d;
  logic [CNTR_WIDTH-1:0]  trig_pos_q, trig_pos_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   trig_pend_q, trig_pend_d;
  logic                   arm_ev, trig_ev, pass, beat, fire, post_le1;
  logic [CNTR_WIDTH-1:0]  post_last;

  axis_trig_edge u_arm_edge (
    .aclk    (aclk),
    .aresetn (aresetn),
    .level   (arm),
    .rise    (arm_ev)
  );

  axis_trig_edge u_trig_edge (
    .aclk    (aclk),
    .aresetn (aresetn),
    .level   (trigger),
    .rise    (trig_ev)
  );

  assign pass          = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = pass & s_axis_tvalid;
  assign s_axis_tready = pass ? m_axis_tready : NonBlk;
  assign beat          = m_axis_tvalid & m_axis_tready;
  assign post_le1      = (cfg_post <= CNTR_WIDTH'(1));
  assign post_last     = cfg_post - CNTR_WIDTH'(1);

  assign trigger_pos = trig_pos_q;
  assign frame_cnt   = frame_q;
  assign state_o     = state_q;

  // Next-state, counters and tlast.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_pos_d   = trig_pos_q;
    frame_d      = frame_q;
    trig_pend_d  = 1'b0;
    m_axis_tlast = 1'b0;
    fire         = 1'b0;
    if (beat) begin
      pos_d = pos_q + CNTR_WIDTH'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (arm_ev) begin
          state_d   = StPre;
          pos_d     = '0;
          pre_cnt_d = '0;
        end
      end
      StPre: begin
        if (arm_ev) begin
          pos_d     = '0;
          pre_cnt_d = '0;
        end else begin
          if (beat) begin
            pre_cnt_d = pre_cnt_q + CNTR_WIDTH'(1);
          end
          if (pre_cnt_q >= cfg_pre) begin
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (arm_ev) begin
          state_d   = StPre;
          pos_d     = '0;
          pre_cnt_d = '0;
        end else if (trig_ev || trig_pend_q) begin
          m_axis_tlast = post_le1 & m_axis_tvalid;
          if (beat) begin
            fire       = 1'b1;
            trig_pos_d = pos_q;
            post_cnt_d = CNTR_WIDTH'(1);
            state_d    = post_le1 ? StDone : StPost;
          end else begin
            // Trigger seen while stalled: hold it for the next accepted beat.
            trig_pend_d = 1'b1;
          end
        end
      end
      StPost: begin
        m_axis_tlast = (post_cnt_q == post_last) & m_axis_tvalid;
        if (beat) begin
          post_cnt_d = post_cnt_q + CNTR_WIDTH'(1);
          if (post_cnt_q == post_last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        frame_d = frame_q + FRAME_WIDTH'(1);
        if (cfg_continuous) begin
          state_d   = StPre;
          pre_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_pos_q  <= '0;
      frame_q     <= '0;
      trig_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_pos_q  <= trig_pos_d;
      frame_q     <= frame_d;
      trig_pend_q <= trig_pend_d;
    end
  end

`ifdef AXIS_TRIG_TIMESTAMP_EN
  logic [CNTR_WIDTH-1:0] ts_cnt_q, trig_ts_q;

  // Free-running cycle counter, sampled on the trigger beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + CNTR_WIDTH'(1);
      if (fire) begin
        trig_ts_q <= ts_cnt_q;
      end
    end
  end

  assign trig_timestamp = trig_ts_q;
`else
  logic unused_fire;
  assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_axis_trigger_packetizer.sv
// Directed bench for axis_trigger_packetizer: a table of single-frame captures plus
// hand-written continuous, backpressure and reset-in-frame sequences.
module tb_axis_trigger_packetizer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_pre, cfg_post;
  logic        cfg_continuous, arm, trigger;
  logic [31:0] trigger_pos, nb_trigger_pos;
  logic [15:0] frame_cnt, nb_frame_cnt;
  logic [2:0]  state_o, nb_state_o;
  logic        s_tready, nb_s_tready;
  logic [31:0] s_tdata, m_tdata, nb_m_tdata;
  logic        s_tvalid, m_tready;
  logic        m_tvalid, m_tlast, nb_m_tvalid, nb_m_tlast;
`ifdef AXIS_TRIG_TIMESTAMP_EN
  logic [31:0] trig_ts, nb_trig_ts;
`endif

  always #5 aclk = ~aclk;

  axis_trigger_packetizer dut (
    .aclk (aclk), .aresetn (aresetn), .cfg_pre (cfg_pre), .cfg_post (cfg_post),
    .cfg_continuous (cfg_continuous), .arm (arm), .trigger (trigger),
    .trigger_pos (trigger_pos), .frame_cnt (frame_cnt), .state_o (state_o),
    .s_axis_tready (s_tready), .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid),
    .m_axis_tready (m_tready), .m_axis_tdata (m_tdata), .m_axis_tvalid (m_tvalid),
    .m_axis_tlast (m_tlast)
`ifdef AXIS_TRIG_TIMESTAMP_EN
    , .trig_timestamp (trig_ts)
`endif
  );

  axis_trigger_packetizer #(.NON_BLOCKING ("TRUE")) dut_nb (
    .aclk (aclk), .aresetn (aresetn), .cfg_pre (cfg_pre), .cfg_post (cfg_post),
    .cfg_continuous (cfg_continuous), .arm (arm), .trigger (trigger),
    .trigger_pos (nb_trigger_pos), .frame_cnt (nb_frame_cnt), .state_o (nb_state_o),
    .s_axis_tready (nb_s_tready), .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid),
    .m_axis_tready (m_tready), .m_axis_tdata (nb_m_tdata), .m_axis_tvalid (nb_m_tvalid),
    .m_axis_tlast (nb_m_tlast)
`ifdef AXIS_TRIG_TIMESTAMP_EN
    , .trig_timestamp (nb_trig_ts)
`endif
  );

  typedef struct {
    int pre;
    int post;
    int h_from;   // trigger level high for beats h_from..h_to
    int h_to;
    int p2;       // extra one-beat trigger pulse
    int exp_pos;
    int exp_last;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   data_err = 0;
  int   beats, last0, last1, nlast;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic do_reset();
    aresetn = 1'b0; arm = 1'b0; trigger = 1'b0; cfg_continuous = 1'b0;
    s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = '0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    @(posedge aclk); #1;
    arm = 1'b0;
    beats = 0; last0 = -1; last1 = -1; nlast = 0;
  endtask

  // Sample combinational outputs for this cycle, tally the beat, then advance.
  task automatic sample_and_step();
    s_tdata = $urandom;
    #1;
    if (m_tdata !== s_tdata) data_err++;
    if (m_tvalid && m_tready) begin
      if (m_tlast) begin
        if (nlast == 0) last0 = beats; else last1 = beats;
        nlast++;
      end
      beats++;
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    int exp_pos;
    bit fired;
    vecs[0] = '{pre: 4, post: 3, h_from: 7, h_to: 7, p2: -1, exp_pos: 7,  exp_last: 9};
    vecs[1] = '{pre: 4, post: 3, h_from: 2, h_to: 2, p2: 6,  exp_pos: 6,  exp_last: 8};
    vecs[2] = '{pre: 2, post: 0, h_from: 4, h_to: 4, p2: -1, exp_pos: 4,  exp_last: 4};
    vecs[3] = '{pre: 2, post: 1, h_from: 4, h_to: 4, p2: -1, exp_pos: 4,  exp_last: 4};
    vecs[4] = '{pre: 4, post: 2, h_from: 4, h_to: 4, p2: 6,  exp_pos: 6,  exp_last: 7};
    vecs[5] = '{pre: 2, post: 2, h_from: 1, h_to: 8, p2: 10, exp_pos: 10, exp_last: 11};

    cfg_pre = 32'd4; cfg_post = 32'd3;
    do_reset();
    #1;
    check("rst_state", state_o, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tready", s_tready, 0);
    check("rst_nb_tready", nb_s_tready, 1);
    check("rst_trigger_pos", trigger_pos, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Single-frame captures from the table.
    foreach (vecs[i]) begin
      do_reset();
      cfg_pre = 32'(vecs[i].pre); cfg_post = 32'(vecs[i].post);
      arm_pulse();
      for (int c = 0; c < 40; c++) begin
        trigger = ((beats >= vecs[i].h_from) && (beats <= vecs[i].h_to)) || (beats == vecs[i].p2);
        sample_and_step();
      end
      trigger = 1'b0;
      check($sformatf("v%0d_trigger_pos", i), trigger_pos, vecs[i].exp_pos);
      check($sformatf("v%0d_last_beat", i), last0, vecs[i].exp_last);
      check($sformatf("v%0d_tlast_count", i), nlast, 1);
      check($sformatf("v%0d_beats", i), beats, vecs[i].exp_last + 1);
      check($sformatf("v%0d_frame_cnt", i), frame_cnt, 1);
      check($sformatf("v%0d_state", i), state_o, 0);
    end
    check("tdata_passthrough_errors", data_err, 0);

    // Continuous re-arm: two frames, pos keeps counting across them.
    do_reset();
    cfg_pre = 32'd2; cfg_post = 32'd2; cfg_continuous = 1'b1;
    arm_pulse();
    for (int c = 0; c < 60 && beats < 16; c++) begin
      trigger = (beats == 3) || (beats == 9);
      sample_and_step();
    end
    trigger = 1'b0;
    check("cont_beats", beats, 16);
    check("cont_tlast_count", nlast, 2);
    check("cont_last0", last0, 4);
    check("cont_last1", last1, 10);
    check("cont_trigger_pos", trigger_pos, 9);
    check("cont_frame_cnt", frame_cnt, 2);
    check("cont_state_armed", state_o, 2);

    // Backpressure: trigger arrives while stalled, lands on the next accepted beat.
    do_reset();
    cfg_pre = 32'd2; cfg_post = 32'd3; cfg_continuous = 1'b0;
    arm_pulse();
    exp_pos = -1; fired = 1'b0; data_err = 0;
    for (int c = 0; c < 80; c++) begin
      m_tready = (c % 4) >= 2;
      trigger = 1'b0;
      if (!fired && beats >= 5 && !m_tready) begin
        trigger = 1'b1; fired = 1'b1; exp_pos = beats;
      end
      #1;
      if (m_tvalid && (s_tready !== m_tready)) data_err++;
      sample_and_step();
    end
    trigger = 1'b0; m_tready = 1'b1;
    check("bp_trigger_pos", trigger_pos, exp_pos);
    check("bp_last_beat", last0, exp_pos + 2);
    check("bp_tlast_count", nlast, 1);
    check("bp_frame_cnt", frame_cnt, 1);
    check("bp_ready_follow_errors", data_err, 0);

    // Reset in the middle of the post phase.
    do_reset();
    cfg_pre = 32'd0; cfg_post = 32'd5;
    arm_pulse();
    for (int c = 0; c < 20 && beats < 4; c++) begin
      trigger = (beats == 2);
      sample_and_step();
    end
    trigger = 1'b0;
    check("mid_state_post", state_o, 3);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("mid_rst_state", state_o, 0);
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_trigger_pos", trigger_pos, 0);
    check("mid_rst_tready", s_tready, 0);
    check("mid_rst_nb_tready", nb_s_tready, 1);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("idle_nb_tready", nb_s_tready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
